// File: rtl/vov_pkg.sv
// Shared types and elaboration-time helpers for the VOV integrate-and-fire stage.
package vov_pkg;

  typedef enum logic {INTEG = 1'b0, REFRACT = 1'b1} state_t;

  function automatic int vov_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Bits needed to hold 0..maxval, never less than one.
  function automatic int width_for(input int maxval);
    int r;
    r = vov_clog2(maxval + 1);
    return (r < 1) ? 1 : r;
  endfunction

  // True when the low k bits are ones packed from the MSB followed by zeros.
  function automatic logic therm_valid(input logic [31:0] v, input int k);
    logic seen_zero;
    logic ok;
    seen_zero = 1'b0;
    ok        = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (i < k) begin
        if (!v[i])         seen_zero = 1'b1;
        else if (seen_zero) ok       = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/therm_decoder.sv
// Combinational popcount plus thermometer-code validity check for one K-bit vector.
module therm_decoder
  import vov_pkg::*;
#(
  parameter int K  = 4,
  parameter int CW = 3
) (
  input  logic [K-1:0]  i_vec,
  output logic [CW-1:0] o_cnt,
  output logic          o_valid
);

  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < K; i++) o_cnt = o_cnt + CW'(i_vec[i]);
    o_valid = therm_valid(32'(i_vec), K);
  end

endmodule

// File: rtl/vov_integrator.sv
// Frame-sampled thermometer integrator with saturating potential, leak, threshold
// spike and whole-frame refractory period.
module vov_integrator
  import vov_pkg::*;
#(
  parameter int K      = 4,
  parameter int W      = 8,
  parameter int THRESH = 16,
  parameter int LEAK   = 1,
  parameter int REFRAC = 2,
  parameter int ALIGN  = K - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [K-1:0] vov_in,
  output logic         spike,
  output logic         frame_done,
  output logic [W-1:0] pot,
  output logic         refractory,
  output logic         code_err
);

  localparam int CW = width_for(K);
  localparam int PW = width_for(K - 1);
  localparam int RW = width_for(REFRAC);

  logic [PW-1:0] r_phase;
  logic          w_sample;
  logic [CW-1:0] w_cnt;
  logic          w_valid;

  logic          r_s1_valid;
  logic [CW-1:0] r_s1_cnt;
  logic          r_code_err;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_pot, w_pot_nxt;
  logic [RW-1:0] r_rcnt, w_rcnt_nxt;
  logic          r_spike, w_spike_nxt;
  logic          r_fd, w_fd_nxt;

  logic [W:0]    w_sum_ext;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_lk;

  assign w_sample = (r_phase == PW'(ALIGN));

  therm_decoder #(.K(K), .CW(CW)) u_dec (
    .i_vec   (vov_in),
    .o_cnt   (w_cnt),
    .o_valid (w_valid)
  );

  // Saturate on the carry out, then floor the leak at zero.
  assign w_sum_ext = {1'b0, r_pot} + (W+1)'(r_s1_cnt);
  assign w_sum     = w_sum_ext[W] ? '1 : w_sum_ext[W-1:0];
  assign w_lk      = (32'(w_sum) > 32'(LEAK)) ? W'(32'(w_sum) - 32'(LEAK)) : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_pot_nxt   = r_pot;
    w_rcnt_nxt  = r_rcnt;
    w_spike_nxt = 1'b0;
    w_fd_nxt    = 1'b0;
    if (r_s1_valid) begin
      w_fd_nxt = 1'b1;
      case (r_state)
        INTEG: begin
          if (32'(w_lk) >= 32'(THRESH)) begin
            w_pot_nxt   = '0;
            w_spike_nxt = 1'b1;
            if (REFRAC != 0) begin
              w_state_nxt = REFRACT;
              w_rcnt_nxt  = RW'(REFRAC);
            end
          end else begin
            w_pot_nxt = w_lk;
          end
        end
        REFRACT: begin
          w_pot_nxt  = '0;
          w_rcnt_nxt = r_rcnt - 1'b1;
          if (r_rcnt == RW'(1)) w_state_nxt = INTEG;
        end
        default: w_state_nxt = INTEG;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= INTEG;
    else if (clr) r_state <= INTEG;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_code_err <= 1'b0;
      r_pot      <= '0;
      r_rcnt     <= '0;
      r_spike    <= 1'b0;
      r_fd       <= 1'b0;
    end else if (clr) begin
      r_phase    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_cnt   <= '0;
      r_code_err <= 1'b0;
      r_pot      <= '0;
      r_rcnt     <= '0;
      r_spike    <= 1'b0;
      r_fd       <= 1'b0;
    end else begin
      r_phase    <= (r_phase == PW'(K - 1)) ? '0 : r_phase + 1'b1;
      r_s1_valid <= w_sample;
      if (w_sample) begin
        r_s1_cnt <= w_cnt;
        if (!w_valid) r_code_err <= 1'b1;
      end
      r_pot   <= w_pot_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_spike <= w_spike_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign spike      = r_spike;
  assign frame_done = r_fd;
  assign pot        = r_pot;
  assign refractory = (r_state == REFRACT);
  assign code_err   = r_code_err;

endmodule

// File: tb/tb_vov_integrator.sv
// Bench for vov_integrator: frame-level reference model compared every cycle,
// directed literal checks, and a second small-W instance for saturation.
module tb_vov_integrator;

  localparam int K      = 4;
  localparam int W      = 8;
  localparam int THRESH = 16;
  localparam int LEAK   = 1;
  localparam int REFRAC = 2;
  localparam int ALIGN  = K - 1;
  localparam int MAXP   = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         clr, clr2;
  logic [K-1:0] vov_in, vov2;
  logic         spike, frame_done, refractory, code_err;
  logic [W-1:0] pot;
  logic         spike2, fd2, refr2, err2;
  logic [3:0]   pot2;

  vov_integrator #(.K(K), .W(W), .THRESH(THRESH), .LEAK(LEAK), .REFRAC(REFRAC), .ALIGN(ALIGN)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vov_in(vov_in),
    .spike(spike), .frame_done(frame_done), .pot(pot),
    .refractory(refractory), .code_err(code_err)
  );

  vov_integrator #(.K(4), .W(4), .THRESH(15), .LEAK(0), .REFRAC(2), .ALIGN(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .vov_in(vov2),
    .spike(spike2), .frame_done(fd2), .pot(pot2),
    .refractory(refr2), .code_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [K-1:0] therm_of(input int n);
    int full;
    full = (1 << K) - 1;
    return K'(full ^ ((1 << (K - n)) - 1));
  endfunction

  // Reference model: frame arithmetic on plain integers.
  int m_phase, m_pc, m_pot, m_refr, s, l;
  bit m_pv, m_spike, m_fd, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_phase = 0; m_pv = 0; m_pc = 0; m_pot = 0; m_refr = 0;
      m_spike = 0; m_fd = 0; m_err = 0;
    end else begin
      m_spike = 0;
      m_fd    = 0;
      if (m_pv) begin
        m_fd = 1;
        if (m_refr > 0) begin
          m_refr--;
          m_pot = 0;
        end else begin
          s = m_pot + m_pc;
          if (s > MAXP) s = MAXP;
          l = s - LEAK;
          if (l < 0) l = 0;
          if (l >= THRESH) begin
            m_pot = 0; m_spike = 1; m_refr = REFRAC;
          end else m_pot = l;
        end
      end
      m_pv = (m_phase == ALIGN);
      if (m_pv) begin
        m_pc = $countones(vov_in);
        if (vov_in != therm_of(m_pc)) m_err = 1;
      end
      m_phase = (m_phase + 1) % K;
    end
  end

  int  n_chk, n_fail;
  bit  done;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_fd(input bit second, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(second ? fd2 : frame_done) && cyc < 40);
    if (cyc >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_done_timeout actual=none expected=pulse within 40 cycles t=%0t", $time);
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  int c;
  int exp_leak[6] = '{4, 3, 2, 1, 0, 0};

  initial begin
    n_chk = 0; n_fail = 0; done = 0;
    rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0; vov_in = '0; vov2 = '0;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (!done) begin
            n_chk++;
            if (spike !== m_spike || frame_done !== m_fd || pot !== W'(m_pot) ||
                refractory !== (m_refr > 0) || code_err !== m_err) begin
              n_fail++;
              $display("FAIL cycle_cmp t=%0t dut spike=%b fd=%b pot=%0d refr=%b err=%b model spike=%0b fd=%0b pot=%0d refr=%0b err=%0b",
                       $time, spike, frame_done, pot, refractory, code_err,
                       m_spike, m_fd, m_pot, (m_refr > 0), m_err);
            end
          end
        end
      end
      begin
        repeat (2) @(negedge clk);
        chk("reset_spike", int'(spike), 0);
        chk("reset_fd", int'(frame_done), 0);
        chk("reset_pot", int'(pot), 0);
        chk("reset_refr", int'(refractory), 0);
        chk("reset_err", int'(code_err), 0);
        vov_in = 4'b1111;
        rst_n = 1'b1;

        // Full vectors: ramp to threshold, spike, refractory, resume.
        for (int i = 1; i <= 5; i++) begin
          wait_fd(0, c);
          chk("ramp_pot", int'(pot), 3 * i);
          chk("ramp_nospike", int'(spike), 0);
        end
        wait_fd(0, c);
        chk("f6_spike", int'(spike), 1);
        chk("f6_pot", int'(pot), 0);
        chk("f6_refr", int'(refractory), 1);
        wait_fd(0, c);
        chk("f7_pot", int'(pot), 0);
        chk("f7_refr", int'(refractory), 1);
        wait_fd(0, c);
        chk("f8_pot", int'(pot), 0);
        chk("f8_refr", int'(refractory), 0);
        wait_fd(0, c);
        chk("f9_pot", int'(pot), 3);

        // Leak down to zero without underflow.
        do_clr();
        wait_fd(0, c);
        chk("leak_setup3", int'(pot), 3);
        vov_in = 4'b1110;
        wait_fd(0, c);
        chk("leak_setup5", int'(pot), 5);
        vov_in = 4'b0000;
        for (int i = 0; i < 6; i++) begin
          wait_fd(0, c);
          chk("leak_pot", int'(pot), exp_leak[i]);
          chk("leak_nospike", int'(spike), 0);
        end

        // Invalid code still counted, sticky error, cleared by clr.
        vov_in = 4'b0101;
        do_clr();
        wait_fd(0, c);
        chk("err_pot", int'(pot), 1);
        chk("err_flag", int'(code_err), 1);
        vov_in = 4'b0000;
        do_clr();
        chk("clr_err", int'(code_err), 0);
        chk("clr_pot", int'(pot), 0);
        wait_fd(0, c);
        chk("clr_phase_latency", c, ALIGN + 2);

        // Asynchronous reset mid-frame.
        vov_in = 4'b1111;
        do_clr();
        repeat (3) wait_fd(0, c);
        chk("prerst_pot", int'(pot), 9);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pot", int'(pot), 0);
        chk("arst_spike", int'(spike), 0);
        chk("arst_fd", int'(frame_done), 0);
        chk("arst_refr", int'(refractory), 0);
        chk("arst_err", int'(code_err), 0);
        @(negedge clk); rst_n = 1'b1;
        wait_fd(0, c);
        chk("rst_first_fd", c, ALIGN + 2);
        chk("rst_first_pot", int'(pot), 3);

        // Small-W instance: saturation at 15 reaches THRESH=15.
        vov2 = 4'b1111;
        @(negedge clk); clr2 = 1'b1;
        @(negedge clk); clr2 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
          wait_fd(1, c);
          chk("w4_pot", int'(pot2), 4 * i);
        end
        vov2 = 4'b1100;
        wait_fd(1, c);
        chk("w4_pot14", int'(pot2), 14);
        chk("w4_nospike", int'(spike2), 0);
        vov2 = 4'b1111;
        wait_fd(1, c);
        chk("w4_sat_spike", int'(spike2), 1);
        chk("w4_sat_pot", int'(pot2), 0);

        // Random traffic, including off-phase junk and occasional clr.
        for (int i = 0; i < 1200; i++) begin
          @(posedge clk); #2;
          if ($urandom_range(0, 99) < 60) vov_in = therm_of($urandom_range(1, 4));
          else                            vov_in = K'($urandom);
          clr = ($urandom_range(0, 99) < 2);
          if (i == 700) begin
            #1 rst_n = 1'b0;
            #1 rst_n = 1'b1;
          end
        end
        @(posedge clk); #2 clr = 1'b0;
        repeat (3) @(negedge clk);
        done = 1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
